ttl_74299_sync: RTL and testbench
=================================

# ttl_74299_sync

Synchronous 8-bit universal shift/storage register with multiplexed parallel I/O. It is modelled on the 74LS299 and is the parallel-to-serial transmit end paired with the D-type capture latches in the video and sprite paths. It loads a byte from the shared data bus, then shifts it out serially at pixel rate (left or right), or holds it. It is a clocked FPGA rendition: one clock, synchronous active-low clear, no asynchronous paths.

## Interface
Parameters:
- WIDTH, 8: register width in bits; all bus ports scale with it.
- DELAY_RISE, 0: simulation rise delay (ns) on every output.
- DELAY_FALL, 0: simulation fall delay (ns) on every output.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Clear_bar  input  1  reset, synchronous, active-low; sampled on rising Clk.
- S0  input  1  mode select bit 0.
- S1  input  1  mode select bit 1.
- OE1_bar  input  1  output enable 1, active-low.
- OE2_bar  input  1  output enable 2, active-low.
- DSR  input  1  serial data in for shift-right.
- DSL  input  1  serial data in for shift-left.
- IO_in  input  WIDTH  parallel bus as seen by the chip (load source).
- IO_out  output  WIDTH  register contents driven onto bus.
- IO_oe  output  1  1 = IO_out valid/driving bus; 0 = high-Z equivalent.
- Q0  output  1  register bit 0, always driven (cascade/serial out).
- Q7  output  1  register bit WIDTH-1, always driven (cascade/serial out).

## Operation
- Internal state: register R[WIDTH-1:0]. IO_out = R, Q0 = R[0], Q7 = R[WIDTH-1].
- Rising Clk, priority order:
  - Clear_bar=0: R <= 0, regardless of S1/S0.
  - {S1,S0}=00: hold, R unchanged.
  - {S1,S0}=01: shift right (toward Q7). R[0] <= DSR; R[i] <= R[i-1] for i=1..WIDTH-1.
  - {S1,S0}=10: shift left (toward Q0). R[WIDTH-1] <= DSL; R[i] <= R[i+1] for i=0..WIDTH-2.
  - {S1,S0}=11: parallel load, R <= IO_in.
- IO_oe = ~OE1_bar & ~OE2_bar & ~(S1 & S0). It is combinational and forced 0 in load mode so the bus can be driven externally.
- Q0 and Q7 are unaffected by OE1_bar and OE2_bar.
- Two instances cascade: A.Q7 feeds B.DSR, and B.Q0 feeds A.DSL. This forms a 2·WIDTH register with no added latency.
- X or Z on mode inputs: no requirement beyond simulation propagation. The bench must not drive them.

## Timing
- Reset: on the first rising Clk with Clear_bar=0, R, IO_out, Q0 and Q7 become 0. Until that first edge, R is unspecified (no asynchronous clear).
- Clear_bar deasserted mid-shift: the cycle with Clear_bar=0 wins and clears R. Mode operation resumes on the next edge from R=0.
- Latency is one Clk from mode, serial or parallel input to R. Outputs follow R after DELAY_RISE/DELAY_FALL only.
- IO_oe has zero-cycle (combinational) response to S1, S0, OE1_bar and OE2_bar.
- Mode change takes effect on the same edge at which the new S1/S0 is sampled. There is no mode pipeline.
- Shift by one bit per enabled edge. After WIDTH shift-right edges with DSR=0, R=0.
- Load with IO_in equal to the current IO_out value is legal and is a hold.

## Test plan
- Reset: R preloaded 0xA5, Clear_bar=0 with {S1,S0}=11, IO_in=0xFF, one edge -> R=0x00, Q0=0, Q7=0.
- Load then shift right: load 0x81; set {S1,S0}=01, DSR=0, then 8 edges.
  - Q7 sequence: 1,0,0,0,0,0,0,1 (sampled before each edge).
  - Final R=0x00.
- Shift left: load 0x01; set {S1,S0}=10, DSL=1, then 3 edges.
  - R steps 0x80, 0xC0, 0xE0.
  - Q0 sequence: 1,0,0.
- Hold and output enable:
  - Load 0x3C, {S1,S0}=00, 5 edges -> R stays 0x3C.
  - OE1_bar=0, OE2_bar=0 -> IO_oe=1, IO_out=0x3C.
  - OE2_bar=1 -> IO_oe=0.
  - {S1,S0}=11 with both OE low -> IO_oe=0.
- Cascade: two instances, A loaded 0xFF, B loaded 0x00, 8 shift-right edges with A.DSR=0 -> A=0x00, B=0xFF.
- Mid-operation clear: during a shift-right of 0xF0, assert Clear_bar=0 for one edge after 2 shifts, then release.
  - After the clear edge, R=0x00.
  - Next edge with DSR=1 gives R=0x01.

Source files
------------

// File: rtl/ttl_74299_sync_if.sv
// Bus bundle for ttl_74299_sync: mode/enable/serial controls in, register contents out.
// master drives the controls and the parallel bus; slave is the register itself.
interface ttl_74299_sync_if #(
    parameter int WIDTH = 8
);
    logic             S0;
    logic             S1;
    logic             OE1_bar;
    logic             OE2_bar;
    logic             DSR;
    logic             DSL;
    logic [WIDTH-1:0] IO_in;
    logic [WIDTH-1:0] IO_out;
    logic             IO_oe;
    logic             Q0;
    logic             Q7;

    modport master (
        output S0,
        output S1,
        output OE1_bar,
        output OE2_bar,
        output DSR,
        output DSL,
        output IO_in,
        input  IO_out,
        input  IO_oe,
        input  Q0,
        input  Q7
    );

    modport slave (
        input  S0,
        input  S1,
        input  OE1_bar,
        input  OE2_bar,
        input  DSR,
        input  DSL,
        input  IO_in,
        output IO_out,
        output IO_oe,
        output Q0,
        output Q7
    );
endinterface

// File: rtl/ttl_74299_sync.sv
// Clocked 74LS299-style universal shift/storage register: hold, shift right/left,
// parallel load, synchronous active-low clear, combinational bus output enable.
module ttl_74299_sync #(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input logic              Clk,
    input logic              Clear_bar,
    ttl_74299_sync_if.slave  bus
);

    // Output delays are a simulation-only notion; this rendition is zero-delay.
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
        $error("ttl_74299_sync: DELAY_RISE/DELAY_FALL must be non-negative");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;

    always_comb begin
        r_d = r_q;
        unique case ({bus.S1, bus.S0})
            2'b00: r_d = r_q;
            2'b01: r_d = {r_q[WIDTH-2:0], bus.DSR};
            2'b10: r_d = {bus.DSL, r_q[WIDTH-1:1]};
            2'b11: r_d = bus.IO_in;
            default: r_d = r_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign bus.IO_out = r_q;
    assign bus.Q0     = r_q[0];
    assign bus.Q7     = r_q[WIDTH-1];
    // Released during load so an external driver can own the bus.
    assign bus.IO_oe  = ~bus.OE1_bar & ~bus.OE2_bar & ~(bus.S1 & bus.S0);

endmodule

// File: tb/tb_ttl_74299_sync.sv
// Directed self-checking bench for ttl_74299_sync: reset, shifts, hold/enable,
// cascade of two instances, mid-shift clear and back-to-back mode changes.
module tb_ttl_74299_sync;

    logic clk;
    logic clear_bar;
    int   n_tests;
    int   n_fail;

    ttl_74299_sync_if #(.WIDTH(8)) if_s ();
    ttl_74299_sync_if #(.WIDTH(8)) if_a ();
    ttl_74299_sync_if #(.WIDTH(8)) if_b ();

    ttl_74299_sync #(.WIDTH(8)) u_dut (
        .Clk       (clk),
        .Clear_bar (clear_bar),
        .bus       (if_s)
    );

    ttl_74299_sync #(.WIDTH(8)) u_casc_a (
        .Clk       (clk),
        .Clear_bar (clear_bar),
        .bus       (if_a)
    );

    ttl_74299_sync #(.WIDTH(8)) u_casc_b (
        .Clk       (clk),
        .Clear_bar (clear_bar),
        .bus       (if_b)
    );

    assign if_b.DSR = if_a.Q7;
    assign if_a.DSL = if_b.Q0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic s1, input logic s0);
        if_s.S1 = s1;
        if_s.S0 = s0;
    endtask

    task automatic load(input logic [7:0] val);
        set_mode(1'b1, 1'b1);
        if_s.IO_in = val;
        step();
    endtask

    task automatic test_reset();
        load(8'hA5);
        n_tests++;
        if (if_s.IO_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_preload: got %h expected %h", if_s.IO_out, 8'hA5);
        end
        clear_bar  = 1'b0;
        if_s.IO_in = 8'hFF;
        step();
        clear_bar = 1'b1;
        n_tests++;
        if (if_s.IO_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_r: got %h expected %h", if_s.IO_out, 8'h00);
        end
        n_tests++;
        if (if_s.Q0 !== 1'b0 || if_s.Q7 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_q0q7: got %b%b expected 00", if_s.Q0, if_s.Q7);
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_q7;
        exp_q7 = 8'b1000_0001;
        load(8'h81);
        set_mode(1'b0, 1'b1);
        if_s.DSR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (if_s.Q7 !== exp_q7[i]) begin
                n_fail++;
                $display("FAIL shr_q7[%0d]: got %b expected %b", i, if_s.Q7, exp_q7[i]);
            end
            step();
        end
        n_tests++;
        if (if_s.IO_out !== 8'h00) begin
            n_fail++;
            $display("FAIL shr_final: got %h expected %h", if_s.IO_out, 8'h00);
        end
    endtask

    task automatic test_shift_left();
        logic [7:0] exp_r [3];
        logic [2:0] exp_q0;
        exp_r[0] = 8'h80;
        exp_r[1] = 8'hC0;
        exp_r[2] = 8'hE0;
        exp_q0   = 3'b001;
        load(8'h01);
        set_mode(1'b1, 1'b0);
        if_s.DSL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (if_s.Q0 !== exp_q0[i]) begin
                n_fail++;
                $display("FAIL shl_q0[%0d]: got %b expected %b", i, if_s.Q0, exp_q0[i]);
            end
            step();
            n_tests++;
            if (if_s.IO_out !== exp_r[i]) begin
                n_fail++;
                $display("FAIL shl_r[%0d]: got %h expected %h", i, if_s.IO_out, exp_r[i]);
            end
        end
    endtask

    task automatic test_hold_oe();
        load(8'h3C);
        set_mode(1'b0, 1'b0);
        if_s.IO_in = 8'hFF;
        repeat (5) step();
        n_tests++;
        if (if_s.IO_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL hold: got %h expected %h", if_s.IO_out, 8'h3C);
        end
        if_s.OE1_bar = 1'b0;
        if_s.OE2_bar = 1'b0;
        #1;
        n_tests++;
        if (if_s.IO_oe !== 1'b1 || if_s.IO_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL oe_on: got oe=%b out=%h expected oe=1 out=3c", if_s.IO_oe,
                     if_s.IO_out);
        end
        if_s.OE2_bar = 1'b1;
        #1;
        n_tests++;
        if (if_s.IO_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe2_off: got %b expected 0", if_s.IO_oe);
        end
        if_s.OE2_bar = 1'b0;
        if_s.OE1_bar = 1'b1;
        #1;
        n_tests++;
        if (if_s.IO_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe1_off: got %b expected 0", if_s.IO_oe);
        end
        if_s.OE1_bar = 1'b0;
        set_mode(1'b1, 1'b1);
        #1;
        n_tests++;
        if (if_s.IO_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_load_mode: got %b expected 0", if_s.IO_oe);
        end
        set_mode(1'b0, 1'b1);
        #1;
        n_tests++;
        if (if_s.IO_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL oe_shift_mode: got %b expected 1", if_s.IO_oe);
        end
        set_mode(1'b0, 1'b0);
        if_s.OE1_bar = 1'b1;
        if_s.OE2_bar = 1'b1;
    endtask

    task automatic test_cascade();
        if_a.S1 = 1'b1;
        if_a.S0 = 1'b1;
        if_b.S1 = 1'b1;
        if_b.S0 = 1'b1;
        if_a.IO_in = 8'hFF;
        if_b.IO_in = 8'h00;
        step();
        if_a.S1 = 1'b0;
        if_b.S1 = 1'b0;
        if_a.DSR = 1'b0;
        repeat (4) step();
        n_tests++;
        if (if_a.IO_out !== 8'hF0 || if_b.IO_out !== 8'h0F) begin
            n_fail++;
            $display("FAIL cascade_mid: got a=%h b=%h expected a=f0 b=0f", if_a.IO_out,
                     if_b.IO_out);
        end
        repeat (4) step();
        n_tests++;
        if (if_a.IO_out !== 8'h00 || if_b.IO_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL cascade_end: got a=%h b=%h expected a=00 b=ff", if_a.IO_out,
                     if_b.IO_out);
        end
        if_a.S0 = 1'b0;
        if_b.S0 = 1'b0;
    endtask

    task automatic test_mid_clear();
        load(8'hF0);
        set_mode(1'b0, 1'b1);
        if_s.DSR = 1'b0;
        repeat (2) step();
        n_tests++;
        if (if_s.IO_out !== 8'hC0) begin
            n_fail++;
            $display("FAIL mclr_shift: got %h expected %h", if_s.IO_out, 8'hC0);
        end
        clear_bar = 1'b0;
        step();
        clear_bar = 1'b1;
        n_tests++;
        if (if_s.IO_out !== 8'h00) begin
            n_fail++;
            $display("FAIL mclr_clear: got %h expected %h", if_s.IO_out, 8'h00);
        end
        if_s.DSR = 1'b1;
        step();
        n_tests++;
        if (if_s.IO_out !== 8'h01) begin
            n_fail++;
            $display("FAIL mclr_resume: got %h expected %h", if_s.IO_out, 8'h01);
        end
    endtask

    task automatic test_back_to_back();
        load(8'hA5);
        set_mode(1'b0, 1'b1);
        if_s.DSR = 1'b1;
        step();
        n_tests++;
        if (if_s.IO_out !== 8'h4B) begin
            n_fail++;
            $display("FAIL b2b_shr: got %h expected %h", if_s.IO_out, 8'h4B);
        end
        set_mode(1'b1, 1'b0);
        if_s.DSL = 1'b0;
        step();
        n_tests++;
        if (if_s.IO_out !== 8'h25) begin
            n_fail++;
            $display("FAIL b2b_shl: got %h expected %h", if_s.IO_out, 8'h25);
        end
        load(8'h25);
        n_tests++;
        if (if_s.IO_out !== 8'h25) begin
            n_fail++;
            $display("FAIL b2b_self_load: got %h expected %h", if_s.IO_out, 8'h25);
        end
        load(8'h5A);
        n_tests++;
        if (if_s.IO_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL b2b_reload: got %h expected %h", if_s.IO_out, 8'h5A);
        end
        set_mode(1'b0, 1'b0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        clear_bar = 1'b1;
        if_s.S0 = 1'b0;  if_s.S1 = 1'b0;  if_s.OE1_bar = 1'b1;  if_s.OE2_bar = 1'b1;
        if_s.DSR = 1'b0; if_s.DSL = 1'b0; if_s.IO_in = 8'h00;
        if_a.S0 = 1'b0;  if_a.S1 = 1'b0;  if_a.OE1_bar = 1'b1;  if_a.OE2_bar = 1'b1;
        if_a.DSR = 1'b0; if_a.IO_in = 8'h00;
        if_b.S0 = 1'b0;  if_b.S1 = 1'b0;  if_b.OE1_bar = 1'b1;  if_b.OE2_bar = 1'b1;
        if_b.DSL = 1'b0; if_b.IO_in = 8'h00;

        test_reset();
        test_shift_right();
        test_shift_left();
        test_hold_oe();
        test_cascade();
        test_mid_clear();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
